// File: rtl/ex.sv
// -----------------------------------------------------------------------------
// ex -- execute stage of the 16-bit pipeline.
//
// Sits directly behind the ID/EX register and turns the latched ex_* operation
// bundle into write-back data for the EX/MEM register.
//   * LOGIC / SHIFT / ARITH / MOVE classes are single-cycle combinational.
//   * MULDIV class (only when EX_MULDIV_EN is defined) is an iterative unsigned
//     shift-add multiplier / restoring divider. It holds the pipeline with
//     stall_req while it works and presents the result in a DONE state.
//     Without EX_MULDIV_EN the MULDIV class simply yields zero, stall_req is
//     tied low and the stall input is ignored.
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   rst        in   asynchronous, active-high reset
//   stall      in   downstream hold; keeps a finished MULDIV result in DONE
//   ex_aluop   in   [2:0] operation within class
//   ex_alusel  in   [2:0] class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MOVE,
//                   5 MULDIV, 6-7 reserved
//   ex_reg0    in   [WIDTH-1:0] operand A
//   ex_reg1    in   [WIDTH-1:0] operand B
//   ex_waddr   in   [3:0] destination register
//   ex_we      in   write enable
//   wdata_o    out  [WIDTH-1:0] result
//   waddr_o    out  [3:0] destination (passthrough)
//   we_o       out  write enable to EX/MEM
//   stall_req  out  request to hold IF/ID/EX
//
// Build option: EX_MULDIV_EN -- include the multiply/divide unit and its FSM.
// -----------------------------------------------------------------------------
module ex #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       ex_aluop,
    input  logic [2:0]       ex_alusel,
    input  logic [WIDTH-1:0] ex_reg0,
    input  logic [WIDTH-1:0] ex_reg1,
    input  logic [3:0]       ex_waddr,
    input  logic             ex_we,
    output logic [WIDTH-1:0] wdata_o,
    output logic [3:0]       waddr_o,
    output logic             we_o,
    output logic             stall_req
);

    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MOVE   = 3'd4;
    localparam logic [2:0] SEL_MULDIV = 3'd5;

    // -------------------------------------------------------------------------
    // Single-cycle ALU. MULDIV, NOP, reserved classes and unlisted ops give 0.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_alu;

    always_comb begin
        // NOTE: default assigned first so every path drives w_alu; no latch.
        w_alu = '0;
        case (ex_alusel)
            SEL_LOGIC: begin
                case (ex_aluop)
                    3'd0:    w_alu = ex_reg0 & ex_reg1;
                    3'd1:    w_alu = ex_reg0 | ex_reg1;
                    3'd2:    w_alu = ex_reg0 ^ ex_reg1;
                    3'd3:    w_alu = ~ex_reg0;
                    default: w_alu = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (ex_aluop)
                    3'd0:    w_alu = ex_reg0 << ex_reg1[3:0];
                    3'd1:    w_alu = ex_reg0 >> ex_reg1[3:0];
                    3'd2:    w_alu = $signed(ex_reg0) >>> ex_reg1[3:0];
                    default: w_alu = '0;
                endcase
            end
            SEL_ARITH: begin
                case (ex_aluop)
                    3'd0:    w_alu = ex_reg0 + ex_reg1;
                    3'd1:    w_alu = ex_reg0 - ex_reg1;
                    3'd2:    w_alu = WIDTH'($signed(ex_reg0) < $signed(ex_reg1));
                    3'd3:    w_alu = WIDTH'(ex_reg0 < ex_reg1);
                    3'd4:    w_alu = WIDTH'(ex_reg0 != ex_reg1);
                    default: w_alu = '0;
                endcase
            end
            SEL_MOVE: begin
                if (ex_aluop == 3'd0) w_alu = ex_reg0;
            end
            default: w_alu = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    // -------------------------------------------------------------------------
    // Iterative multiply / divide.
    // r_acc holds {high, low} halves:
    //   multiply: {partial product, remaining multiplier bits} -> {hi, lo}
    //   divide:   {partial remainder, dividend/quotient bits}  -> {rem, quo}
    // so aluop[0] selects the upper half for MULHI and REMU alike.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;      // multiplicand or divisor
    logic               r_is_div;
    logic               r_hi_sel;

    logic               w_start;
    logic               w_div;
    logic               w_div_zero;
    logic               w_stall_req;
    logic               w_done;
    logic [WIDTH-1:0]   w_mdres;

    assign w_start    = (ex_alusel == SEL_MULDIV) && !ex_aluop[2];
    assign w_div      = ex_aluop[1];
    assign w_div_zero = w_start && w_div && (ex_reg1 == '0);
    assign w_mdres    = r_hi_sel ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

    // Shift-add step: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring-divide step: bring the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift in the quotient bit.
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_step;

    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_opd});
    assign w_div_rem  = w_div_ge ? WIDTH'(w_div_sh - {1'b0, r_opd})
                                 : w_div_sh[WIDTH-1:0];
    assign w_div_step = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_stall_req = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stall_req = 1'b1;
                    // Divide by zero has a fixed answer: skip the iterations.
                    w_next      = w_div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall_req = 1'b1;
                if (r_cnt == '0) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (!stall) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the accumulators are reset as well so an op aborted by reset
        // can never leave a stale result behind.
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_is_div <= 1'b0;
            r_hi_sel <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_div <= w_div;
                        r_hi_sel <= ex_aluop[0];
                        r_opd    <= w_div ? ex_reg1 : ex_reg0;
                        r_cnt    <= CW'(WIDTH - 1);
                        if (w_div_zero)
                            r_acc <= {ex_reg0, DIV_ZERO_Q};
                        else if (w_div)
                            r_acc <= {{WIDTH{1'b0}}, ex_reg0};
                        else
                            r_acc <= {{WIDTH{1'b0}}, ex_reg1};
                    end
                end
                S_BUSY: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    // Clock and downstream stall only matter to the MULDIV unit.
    logic w_unused;
    assign w_unused = ^{clk, stall};
`endif

    // -------------------------------------------------------------------------
    // Output stage. While stalling, nothing may be written; reset silences all.
    // -------------------------------------------------------------------------
    always_comb begin
        wdata_o   = w_alu;
        waddr_o   = ex_waddr;
        we_o      = ex_we;
        stall_req = 1'b0;
`ifdef EX_MULDIV_EN
        if (w_stall_req) begin
            wdata_o   = '0;
            we_o      = 1'b0;
            stall_req = 1'b1;
        end else if (w_done) begin
            wdata_o   = w_mdres;
        end
`endif
        if (rst) begin
            wdata_o   = '0;
            waddr_o   = '0;
            we_o      = 1'b0;
            stall_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex.sv
// -----------------------------------------------------------------------------
// tb_ex -- self-checking bench for the execute stage.
// Directed vectors plus randomized operations compared against a behavioural
// reference computed with plain arithmetic. MULDIV checks are built only when
// EX_MULDIV_EN is defined; otherwise the disabled-unit behaviour is checked.
// -----------------------------------------------------------------------------
module tb_ex;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [15:0] ex_reg0;
    logic [15:0] ex_reg1;
    logic [3:0]  ex_waddr;
    logic        ex_we;
    logic [15:0] wdata_o;
    logic [3:0]  waddr_o;
    logic        we_o;
    logic        stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    ex #(.WIDTH(16), .DIV_ZERO_Q(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .ex_aluop  (ex_aluop),
        .ex_alusel (ex_alusel),
        .ex_reg0   (ex_reg0),
        .ex_reg1   (ex_reg1),
        .ex_waddr  (ex_waddr),
        .ex_we     (ex_we),
        .wdata_o   (wdata_o),
        .waddr_o   (waddr_o),
        .we_o      (we_o),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference for the single-cycle classes.
    function automatic logic [15:0] alu_model(input logic [2:0] sel, input logic [2:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        int sh;
        int sa;
        sh = int'(b[3:0]);
        sa = int'($signed(a));
        case (sel)
            3'd1: case (op)
                3'd0: return a & b;
                3'd1: return a | b;
                3'd2: return a ^ b;
                3'd3: return ~a;
                default: return 16'h0;
            endcase
            3'd2: case (op)
                3'd0: return 16'(a << sh);
                3'd1: return 16'(a >> sh);
                3'd2: return 16'(sa >>> sh);
                default: return 16'h0;
            endcase
            3'd3: case (op)
                3'd0: return 16'(int'(a) + int'(b));
                3'd1: return 16'(int'(a) - int'(b));
                3'd2: return (sa < int'($signed(b))) ? 16'd1 : 16'd0;
                3'd3: return (int'(a) < int'(b)) ? 16'd1 : 16'd0;
                3'd4: return (a != b) ? 16'd1 : 16'd0;
                default: return 16'h0;
            endcase
            3'd4: return (op == 3'd0) ? a : 16'h0;
            default: return 16'h0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] sel, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] wa, input logic we);
        @(negedge clk);
        ex_alusel = sel;
        ex_aluop  = op;
        ex_reg0   = a;
        ex_reg1   = b;
        ex_waddr  = wa;
        ex_we     = we;
        #1;
    endtask

    // Checks all outputs of a zero-latency op against the reference.
    task automatic alu_check(input string tag);
        check({tag, " wdata"}, wdata_o, alu_model(ex_alusel, ex_aluop, ex_reg0, ex_reg1));
        check({tag, " we"}, we_o, ex_we);
        check({tag, " waddr"}, waddr_o, ex_waddr);
        check({tag, " stall_req"}, stall_req, 1'b0);
    endtask

`ifdef EX_MULDIV_EN
    function automatic logic [15:0] md_model(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (op)
            3'd0: return p[15:0];
            3'd1: return p[31:16];
            3'd2: return (b == 16'h0) ? 16'hFFFF : a / b;
            3'd3: return (b == 16'h0) ? a : a % b;
            default: return 16'h0;
        endcase
    endfunction

    // Issues one MULDIV op, measures the stall, checks the result and
    // optionally holds DONE with stall=1 for 'hold' cycles.
    task automatic muldiv_check(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input int hold, input string tag);
        int          n_stall;
        bit          leak;
        logic [15:0] exp_q;
        logic [3:0]  wa;
        exp_q = md_model(op, a, b);
        wa    = 4'($urandom_range(0, 15));
        drive(3'd5, op, a, b, wa, 1'b1);
        n_stall = 0;
        leak    = 1'b0;
        while (stall_req === 1'b1 && n_stall < 40) begin
            if (we_o !== 1'b0 || wdata_o !== 16'h0) leak = 1'b1;
            n_stall++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall cycles"}, n_stall, (op >= 3'd2 && b == 16'h0) ? 32'd1 : 32'd17);
        check({tag, " quiet while stalled"}, leak, 1'b0);
        check({tag, " result"}, wdata_o, exp_q);
        check({tag, " we"}, we_o, 1'b1);
        check({tag, " waddr"}, waddr_o, wa);
        if (hold > 0) begin
            stall = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                #1;
                check({tag, " held result"}, wdata_o, exp_q);
                check({tag, " held stall_req"}, stall_req, 1'b0);
            end
            stall = 1'b0;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        ex_alusel = 3'd3;
        ex_aluop  = 3'd0;
        ex_reg0   = 16'h1234;
        ex_reg1   = 16'h0101;
        ex_waddr  = 4'd5;
        ex_we     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset wdata", wdata_o, 16'h0);
        check("reset waddr", waddr_o, 4'd0);
        check("reset we", we_o, 1'b0);
        check("reset stall_req", stall_req, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // Directed single-cycle vectors.
        drive(3'd3, 3'd0, 16'hFFFF, 16'h0002, 4'd3, 1'b1);
        check("ADD wdata", wdata_o, 16'h0001);
        check("ADD we", we_o, 1'b1);
        check("ADD waddr", waddr_o, 4'd3);
        check("ADD stall_req", stall_req, 1'b0);
        drive(3'd3, 3'd2, 16'h8000, 16'h0001, 4'd1, 1'b1);
        check("SLT", wdata_o, 16'h0001);
        drive(3'd3, 3'd3, 16'h8000, 16'h0001, 4'd1, 1'b1);
        check("SLTU", wdata_o, 16'h0000);
        drive(3'd2, 3'd2, 16'h8000, 16'h0004, 4'd2, 1'b1);
        check("SRA", wdata_o, 16'hF800);
        drive(3'd2, 3'd1, 16'h8000, 16'h0004, 4'd2, 1'b1);
        check("SRL", wdata_o, 16'h0800);
        drive(3'd2, 3'd0, 16'h0001, 16'h000F, 4'd2, 1'b1);
        check("SLL", wdata_o, 16'h8000);
        drive(3'd3, 3'd1, 16'h0000, 16'h0001, 4'd7, 1'b0);
        check("SUB wrap", wdata_o, 16'hFFFF);
        check("SUB we=0", we_o, 1'b0);
        drive(3'd6, 3'd0, 16'hAAAA, 16'h5555, 4'd4, 1'b1);
        check("reserved class", wdata_o, 16'h0000);

        // Randomized single-cycle ops (no MULDIV start).
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  sel;
            logic [2:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            sel = 3'($urandom_range(0, 7));
            op  = 3'($urandom_range(0, 7));
`ifdef EX_MULDIV_EN
            if (sel == 3'd5) op = op | 3'd4;
`endif
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            drive(sel, op, a, b, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            alu_check($sformatf("rand%0d sel%0d op%0d", i, sel, op));
        end

`ifdef EX_MULDIV_EN
        muldiv_check(3'd0, 16'h1234, 16'h0010, 0, "MULLO");
        muldiv_check(3'd1, 16'h1234, 16'h0010, 0, "MULHI");
        muldiv_check(3'd2, 16'd100, 16'd7, 3, "DIVU hold");
        muldiv_check(3'd3, 16'd100, 16'd7, 0, "REMU");
        muldiv_check(3'd2, 16'd5, 16'd0, 0, "DIVU by 0");
        muldiv_check(3'd3, 16'd5, 16'd0, 0, "REMU by 0");
        muldiv_check(3'd0, 16'd3, 16'd4, 0, "b2b MULLO 1");
        muldiv_check(3'd0, 16'd5, 16'd6, 0, "b2b MULLO 2");
        for (int i = 0; i < 6; i++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            muldiv_check(3'($urandom_range(0, 3)), 16'($urandom), b, 0,
                         $sformatf("rand muldiv %0d", i));
        end
        muldiv_check(3'd1, 16'hFFFF, 16'hFFFF, 0, "MULHI max");

        // Reset in BUSY cycle 8 aborts the op with no write.
        drive(3'd5, 3'd0, 16'h00FF, 16'h00FF, 4'd9, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort stall_req", stall_req, 1'b0);
        check("abort we", we_o, 1'b0);
        check("abort wdata", wdata_o, 16'h0);
        @(negedge clk);
        rst       = 1'b0;
        ex_alusel = 3'd3;
        ex_aluop  = 3'd0;
        ex_reg0   = 16'h0010;
        ex_reg1   = 16'h0020;
        ex_waddr  = 4'd6;
        ex_we     = 1'b1;
        #1;
        check("post-reset ADD", wdata_o, 16'h0030);
        check("post-reset ADD we", we_o, 1'b1);
        @(negedge clk);
        #1;
        check("post-reset idle stall_req", stall_req, 1'b0);
        check("post-reset idle wdata", wdata_o, 16'h0030);
`else
        // Disabled unit: MULDIV gives 0, passes we, never stalls.
        drive(3'd5, 3'd0, 16'h0003, 16'h0004, 4'd8, 1'b1);
        check("MULDIV off wdata", wdata_o, 16'h0);
        check("MULDIV off we", we_o, 1'b1);
        check("MULDIV off stall_req", stall_req, 1'b0);
        @(negedge clk);
        #1;
        check("MULDIV off later stall_req", stall_req, 1'b0);
        check("MULDIV off later wdata", wdata_o, 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
